alu_result_tx: RTL and testbench

- Serial transmit end of the ALU operand/result path.
- Captures an `LEN_DATO`-bit ALU result on a start request and sends it LSB-first as an asynchronous UART frame: start bit, data bits, optional even parity, stop.
- Bit timing comes from an internal 16x-oversampling tick generator.
- Sits between the ALU result output and the board TX pin, mirroring the path that loads operands and opcode into the ALU.

---
 rtl/alu_result_tx_if.sv | 13 +
 rtl/alu_result_tx.sv | 105 ++++++++++
 tb/tb_alu_result_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_result_tx_if.sv
// alu_result_tx_if: request/result bus between the ALU result path and the UART transmitter
// Signals: i_tx_start (transmit request), i_dato (result to send),
//          o_tx (serial line), o_tx_busy (frame in progress), o_tx_done (frame complete pulse)
// Modports: master drives the request side, slave is the transmitter.
interface alu_result_tx_if #(parameter int LEN_DATO = 8);
  logic                i_tx_start;
  logic [LEN_DATO-1:0] i_dato;
  logic                o_tx;
  logic                o_tx_busy;
  logic                o_tx_done;
  modport master (output i_tx_start, i_dato, input o_tx, o_tx_busy, o_tx_done);
  modport slave  (input i_tx_start, i_dato, output o_tx, o_tx_busy, o_tx_done);
endinterface

// File: rtl/alu_result_tx.sv
// alu_result_tx: sends a captured ALU result LSB-first as a UART frame (start, data, [even parity], stop)
// Ports: i_clk system clock; i_rst_n async active-low reset;
//        bus (alu_result_tx_if.slave): i_tx_start, i_dato in; o_tx, o_tx_busy, o_tx_done out.
// Parameters: LEN_DATO data bits, DVSR clocks per 16x tick, SB_TICK ticks in stop.
// Option: define ALU_RESULT_TX_PARITY_EN to append an even-parity bit after the data bits.
module alu_result_tx #(
  parameter int LEN_DATO = 8,
  parameter int DVSR     = 163,
  parameter int SB_TICK  = 16
) (
  input logic            i_clk,
  input logic            i_rst_n,
  alu_result_tx_if.slave bus
);
  localparam int BW = DVSR > 1 ? $clog2(DVSR) : 1;
  localparam int SW = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW = LEN_DATO > 1 ? $clog2(LEN_DATO) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t r_st, w_st_n;
  logic [BW-1:0] r_bc, w_bc_n;
  logic [SW-1:0] r_s, w_s_n;
  logic [NW-1:0] r_n, w_n_n;
  logic [LEN_DATO-1:0] r_sh, w_sh_n;
  logic r_tx, r_busy, r_done, w_tx_n, w_tick, w_acc, w_s15, w_last, w_pbit;
  assign w_tick = r_bc == BW'(DVSR - 1);
  assign w_acc  = (r_st == IDLE) && bus.i_tx_start;
  assign w_s15  = w_tick && (r_s == SW'(15));
  assign w_last = r_n == NW'(LEN_DATO - 1);
`ifdef ALU_RESULT_TX_PARITY_EN
  logic r_par;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_par <= 1'b0;
    else if (w_acc) r_par <= ^bus.i_dato;
  assign w_pbit = r_par;
`else
  assign w_pbit = 1'b1;
`endif
  always_comb begin
    w_st_n = r_st;
    w_s_n  = (w_tick && r_st != IDLE) ? r_s + SW'(1) : r_s;
    w_n_n  = r_n;
    w_sh_n = r_sh;
    // baud counter restarts on acceptance so every bit of the frame is exactly 16 ticks
    w_bc_n = (w_acc || w_tick) ? '0 : r_bc + BW'(1);
    case (r_st)
      IDLE: if (bus.i_tx_start) begin
        w_st_n = START;
        w_s_n  = '0;
        w_n_n  = '0;
        w_sh_n = bus.i_dato;
      end
      START: if (w_s15) begin
        w_st_n = DATA;
        w_s_n  = '0;
      end
      DATA: if (w_s15) begin
        w_s_n  = '0;
        w_sh_n = r_sh >> 1;
        w_n_n  = r_n + NW'(1);
`ifdef ALU_RESULT_TX_PARITY_EN
        if (w_last) w_st_n = PARITY;
`else
        if (w_last) w_st_n = STOP;
`endif
      end
      PARITY: if (w_s15) begin
        w_st_n = STOP;
        w_s_n  = '0;
      end
      STOP: if (w_tick && r_s == SW'(SB_TICK - 1)) begin
        w_st_n = IDLE;
        w_s_n  = '0;
      end
      default: w_st_n = IDLE;
    endcase
    // line level is registered from the next state so it changes on the same edge as the state
    w_tx_n = (w_st_n == START) ? 1'b0 :
             (w_st_n == DATA)  ? w_sh_n[0] :
             (w_st_n == PARITY) ? w_pbit : 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_st <= IDLE;
    else r_st <= w_st_n;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_bc   <= '0;
      r_s    <= '0;
      r_n    <= '0;
      r_sh   <= '0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_bc   <= w_bc_n;
      r_s    <= w_s_n;
      r_n    <= w_n_n;
      r_sh   <= w_sh_n;
      r_tx   <= w_tx_n;
      r_busy <= w_st_n != IDLE;
      r_done <= (r_st == STOP) && (w_st_n == IDLE);
    end
  assign bus.o_tx      = r_tx;
  assign bus.o_tx_busy = r_busy;
  assign bus.o_tx_done = r_done;
endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: self-checking bench for alu_result_tx against a frame-level line model
module tb_alu_result_tx;
  localparam int DVSR = 2;
  localparam int SBT  = 16;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BITC = 16 * DVSR;
  localparam int FL   = (16 * (1 + 8 + P) + SBT) * DVSR;
  typedef struct { logic [7:0] d; logic p; } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  vec_t tbl[8];
  alu_result_tx_if #(.LEN_DATO(8)) bus ();
  alu_result_tx #(.LEN_DATO(8), .DVSR(DVSR), .SB_TICK(SBT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // expected line level k clocks after the acceptance edge
  function automatic logic exp_line(input logic [7:0] d, input logic p, input int k);
    int b = k / BITC;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P == 1 && b == 9) return p;
    return 1'b1;
  endfunction
  task automatic go(input logic [7:0] d);
    @(negedge clk);
    bus.i_dato = d;
    bus.i_tx_start = 1'b1;
    @(posedge clk);
    #1;
  endtask
  // called at #1 after the acceptance edge; checks every clock of the frame and the done cycle
  task automatic frame(input logic [7:0] d, input logic p, input int k_mid, input logic [7:0] d_mid,
                       input bit hold, input string nm);
    int errs = 0;
    int first = -1;
    for (int k = 0; k < FL; k++) begin
      if (k == 0 && !hold) bus.i_tx_start = 1'b0;
      if (k == k_mid) begin
        bus.i_dato = d_mid;
        bus.i_tx_start = 1'b1;
      end
      if (k == k_mid + 1 && !hold) bus.i_tx_start = 1'b0;
      if (bus.o_tx !== exp_line(d, p, k) || bus.o_tx_busy !== 1'b1 || bus.o_tx_done !== 1'b0) begin
        errs++;
        if (first < 0) first = k;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_frame_%02h_errcycles(first=%0d)", nm, d, first), errs, 0);
    chk($sformatf("%s_done_%02h", nm, d), {bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 3'b101);
  endtask
  initial begin
    int e;
    logic [7:0] r;
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h03, 1'b0};
    tbl[3] = '{8'h3C, 1'b0};
    tbl[4] = '{8'h00, 1'b0};
    tbl[5] = '{8'hFF, 1'b0};
    tbl[6] = '{8'h5A, 1'b0};
    tbl[7] = '{8'h80, 1'b1};
    bus.i_tx_start = 1'b0;
    bus.i_dato = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.o_tx, 1'b1);
    chk("rst_busy", bus.o_tx_busy, 1'b0);
    chk("rst_done", bus.o_tx_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if ({bus.o_tx, bus.o_tx_busy, bus.o_tx_done} !== 3'b100) e++;
    end
    chk("idle_1000_bad_cycles", e, 0);
    for (int i = 0; i < 8; i++) begin
      go(tbl[i].d);
      frame(tbl[i].d, tbl[i].p, -5, 8'h00, 1'b0, "tbl");
      @(posedge clk);
      #1;
      chk($sformatf("tbl_post_%0d", i), {bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 3'b100);
    end
    go(8'h3C);
    frame(8'h3C, 1'b0, 5 * BITC + 3, 8'hFF, 1'b0, "busyreq");
    @(posedge clk);
    #1;
    chk("busyreq_single_done", {bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 3'b100);
    go(8'h11);
    frame(8'h11, 1'b0, 3 * BITC, 8'h22, 1'b1, "b2b1");
    @(posedge clk);
    #1;
    frame(8'h22, 1'b0, -5, 8'h00, 1'b0, "b2b2");
    go(8'hC3);
    bus.i_tx_start = 1'b0;
    repeat (4 * BITC + 5) @(posedge clk);
    #1;
    chk("pre_rst_busy", bus.o_tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_line", {bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 3'b100);
    e = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if ({bus.o_tx, bus.o_tx_busy, bus.o_tx_done} !== 3'b100) e++;
    end
    chk("midrst_hold_bad_cycles", e, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_idle", {bus.o_tx, bus.o_tx_busy, bus.o_tx_done}, 3'b100);
    go(8'h5A);
    frame(8'h5A, 1'b0, -5, 8'h00, 1'b0, "postrst");
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      go(r);
      frame(r, ^r, -5, 8'h00, 1'b0, "rnd");
      e = 0;
      for (int g = 0; g < 1 + int'($urandom_range(0, 4)); g++) begin
        @(posedge clk);
        #1;
        if ({bus.o_tx, bus.o_tx_busy, bus.o_tx_done} !== 3'b100) e++;
      end
      chk($sformatf("rnd_gap_%0d", i), e, 0);
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
